// File: rtl/fifo_rd_prefetch_pkg.sv
// Shared constants and helpers for the FIFO read-side prefetch stage.
// Provides width derivation and circular pointer increment.
package fifo_rd_prefetch_pkg;

    localparam int DEF_DAT_WIDTH = 32;
    localparam int DEF_RD_LAT    = 1;
    localparam int DEF_DEPTH     = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    function automatic int ptr_inc_wrap(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_rd_prefetch_buf.sv
// Circular landing buffer for prefetched FIFO words.
// Head entry is presented directly from flop storage.
module fifo_rd_prefetch_buf
    import fifo_rd_prefetch_pkg::*;
#(
    parameter  int DAT_WIDTH = DEF_DAT_WIDTH,
    parameter  int DEPTH     = DEF_DEPTH,
    localparam int CW        = clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 wr_en,
    input  logic [DAT_WIDTH-1:0] wr_data,
    input  logic                 pop,
    output logic                 out_valid,
    output logic [DAT_WIDTH-1:0] out_data,
    output logic [CW-1:0]        occupancy,
    output logic                 ovf_err
);

    localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;

    logic [DAT_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic                 full;
    logic                 wr_ok;

    assign full      = (occupancy == CW'(DEPTH));
    assign wr_ok     = wr_en & (~full | pop);
    assign out_valid = (occupancy != '0);
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            ovf_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (wr_ok) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= PW'(ptr_inc_wrap(int'(wr_ptr), DEPTH));
            end
            // a word landing on a full, non-draining buffer is lost
            if (wr_en & full & ~pop) begin
                ovf_err <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= PW'(ptr_inc_wrap(int'(rd_ptr), DEPTH));
            end
            unique case ({wr_ok, pop})
                2'b10:   occupancy <= occupancy + CW'(1);
                2'b01:   occupancy <= occupancy - CW'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_prefetch_d32.sv
// Converts a fixed-latency FIFO read port into a valid/ready stream.
// Reads are issued speculatively against a credit limit.
module fifo_rd_prefetch_d32
    import fifo_rd_prefetch_pkg::*;
#(
    parameter  int DAT_WIDTH = DEF_DAT_WIDTH,
    parameter  int RD_LAT    = DEF_RD_LAT,
    parameter  int DEPTH     = DEF_DEPTH,
    localparam int CW        = clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_op,
    input  logic [DAT_WIDTH-1:0] fifo_rd_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DAT_WIDTH-1:0] out_data,
    output logic [CW-1:0]        occupancy,
    output logic                 ovf_err
);

    logic [CW-1:0]     credit;
    logic [RD_LAT-1:0] pipe;
    logic              arr;
    logic              pop;

    assign arr = pipe[RD_LAT-1];
    assign pop = out_valid & out_ready;

    // credit is registered, so out_ready never reaches the read strobe
    assign fifo_rd_op = reset_n & ~fifo_empty & ~flush
                      & (credit < CW'(DEPTH));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            credit <= '0;
            pipe   <= '0;
        end else if (flush) begin
            credit <= '0;
            pipe   <= '0;
        end else begin
            pipe[0] <= fifo_rd_op;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
            unique case ({fifo_rd_op, pop})
                2'b10:   credit <= credit + CW'(1);
                2'b01:   credit <= credit - CW'(1);
                default: credit <= credit;
            endcase
        end
    end

    fifo_rd_prefetch_buf #(
        .DAT_WIDTH(DAT_WIDTH),
        .DEPTH    (DEPTH)
    ) u_buf (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .wr_en    (arr),
        .wr_data  (fifo_rd_data),
        .pop      (pop),
        .out_valid(out_valid),
        .out_data (out_data),
        .occupancy(occupancy),
        .ovf_err  (ovf_err)
    );

endmodule

// File: tb/tb_fifo_rd_prefetch_d32.sv
// Directed bench for the FIFO read prefetch stage.
// Two instances: RD_LAT=1/DEPTH=4 and RD_LAT=3/DEPTH=5.
module tb_fifo_rd_prefetch_d32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic flush;

    logic        a_empty, a_rd_op, a_valid, a_ready, a_ovf, a_gap;
    logic [31:0] a_rd_data, a_data;
    logic [2:0]  a_occ;

    logic        b_empty, b_rd_op, b_valid, b_ready, b_ovf, b_gap;
    logic [31:0] b_rd_data, b_data;
    logic [2:0]  b_occ;

    logic [31:0] amem [256];
    logic [31:0] bmem [256];
    logic [31:0] bstg [3];
    int ard = 0, awr = 0, brd = 0, bwr = 0;
    int a_err = 0, b_err = 0;

    int total = 0;
    int passed = 0;

    assign a_empty   = (ard == awr) | a_gap;
    assign b_empty   = (brd == bwr) | b_gap;
    assign b_rd_data = bstg[2];

    always @(posedge clk) begin
        if (a_rd_op) begin
            if (ard == awr) a_err <= a_err + 1;
            a_rd_data <= amem[ard];
            ard <= ard + 1;
        end
    end

    always @(posedge clk) begin
        bstg[1] <= bstg[0];
        bstg[2] <= bstg[1];
        if (b_rd_op) begin
            if (brd == bwr) b_err <= b_err + 1;
            bstg[0] <= bmem[brd];
            brd <= brd + 1;
        end
    end

    fifo_rd_prefetch_d32 #(
        .DAT_WIDTH(32), .RD_LAT(1), .DEPTH(4)
    ) u_dut_a (
        .clk(clk), .reset_n(reset_n),
        .fifo_empty(a_empty), .fifo_rd_op(a_rd_op),
        .fifo_rd_data(a_rd_data), .flush(flush),
        .out_valid(a_valid), .out_ready(a_ready),
        .out_data(a_data), .occupancy(a_occ),
        .ovf_err(a_ovf)
    );

    fifo_rd_prefetch_d32 #(
        .DAT_WIDTH(32), .RD_LAT(3), .DEPTH(5)
    ) u_dut_b (
        .clk(clk), .reset_n(reset_n),
        .fifo_empty(b_empty), .fifo_rd_op(b_rd_op),
        .fifo_rd_data(b_rd_data), .flush(1'b0),
        .out_valid(b_valid), .out_ready(b_ready),
        .out_data(b_data), .occupancy(b_occ),
        .ovf_err(b_ovf)
    );

    task automatic test_reset();
        for (int i = 0; i < 16; i++) amem[i] = 32'(i + 1);
        awr = 16;
        a_ready = 1'b1;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (a_rd_op !== 1'b0) $display("FAIL reset_rd_op got %b want 0", a_rd_op);
        else passed++;
        total++;
        if (a_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", a_valid);
        else passed++;
        total++;
        if (a_occ !== 3'd0) $display("FAIL reset_occ got %0d want 0", a_occ);
        else passed++;
        total++;
        if (a_data !== 32'h0) $display("FAIL reset_data got %h want 0", a_data);
        else passed++;
        total++;
        if (a_ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", a_ovf);
        else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        total++;
        if (a_rd_op !== 1'b1) $display("FAIL release_rd_op got %b want 1", a_rd_op);
        else passed++;
    endtask

    task automatic test_throughput();
        int exp = 1;
        int first = -1;
        int gaps = 0;
        for (int c = 0; c < 30; c++) begin
            if (a_valid) begin
                if (first < 0) first = c;
                if (c != first + exp - 1) gaps++;
                total++;
                if (a_data !== 32'(exp))
                    $display("FAIL tput_data got %h want %h", a_data, exp);
                else passed++;
                exp++;
            end
            @(negedge clk);
            #1;
        end
        total++;
        if (first != 2) $display("FAIL tput_first_valid got %0d want 2", first);
        else passed++;
        total++;
        if (exp != 17) $display("FAIL tput_count got %0d want 16", exp - 1);
        else passed++;
        total++;
        if (gaps != 0) $display("FAIL tput_gaps got %0d want 0", gaps);
        else passed++;
        total++;
        if (a_err != 0) $display("FAIL tput_empty_err got %0d want 0", a_err);
        else passed++;
    endtask

    task automatic test_backpressure();
        int n = 0;
        int unstable = 0;
        int exp = 1;
        int first = -1;
        int gaps = 0;
        a_ready = 1'b0;
        for (int i = 0; i < 10; i++) amem[awr + i] = 32'(i + 1);
        awr = awr + 10;
        #1;
        for (int c = 0; c < 12; c++) begin
            if (a_rd_op) n++;
            if (a_valid && a_data !== 32'h1) unstable++;
            @(negedge clk);
            #1;
        end
        total++;
        if (n != 4) $display("FAIL bp_rd_ops got %0d want 4", n);
        else passed++;
        total++;
        if (a_occ !== 3'd4) $display("FAIL bp_occ got %0d want 4", a_occ);
        else passed++;
        total++;
        if (a_valid !== 1'b1 || a_data !== 32'h1)
            $display("FAIL bp_head got %b/%h want 1/1", a_valid, a_data);
        else passed++;
        total++;
        if (unstable != 0) $display("FAIL bp_stable got %0d want 0", unstable);
        else passed++;
        a_ready = 1'b1;
        #1;
        for (int c = 0; c < 20; c++) begin
            if (a_valid) begin
                if (first < 0) first = c;
                if (c != first + exp - 1) gaps++;
                total++;
                if (a_data !== 32'(exp))
                    $display("FAIL bp_data got %h want %h", a_data, exp);
                else passed++;
                exp++;
            end
            @(negedge clk);
            #1;
        end
        total++;
        if (exp != 11 || gaps != 0)
            $display("FAIL bp_drain got %0d/%0d want 10/0", exp - 1, gaps);
        else passed++;
        total++;
        if (a_ovf !== 1'b0) $display("FAIL bp_ovf got %b want 0", a_ovf);
        else passed++;
    endtask

    task automatic test_alternate();
        int ea = 0, eb = 0, aover = 0, bover = 0;
        for (int i = 0; i < 40; i++) begin
            amem[awr + i] = 32'h100 + 32'(i);
            bmem[bwr + i] = 32'h200 + 32'(i);
        end
        awr = awr + 40;
        bwr = bwr + 40;
        for (int c = 0; c < 220; c++) begin
            a_ready = (c >= 200) || (c % 2 == 0);
            b_ready = (c >= 200) || (c % 2 == 1);
            a_gap = (c < 200) && ($urandom_range(0, 3) == 0);
            b_gap = (c < 200) && ($urandom_range(0, 3) == 0);
            #1;
            if (a_valid && a_ready) begin
                total++;
                if (a_data !== 32'h100 + 32'(ea))
                    $display("FAIL alt_a_data got %h want %h", a_data, 32'h100 + ea);
                else passed++;
                ea++;
            end
            if (b_valid && b_ready) begin
                total++;
                if (b_data !== 32'h200 + 32'(eb))
                    $display("FAIL alt_b_data got %h want %h", b_data, 32'h200 + eb);
                else passed++;
                eb++;
            end
            if (a_occ > 3'd4) aover++;
            if (b_occ > 3'd5) bover++;
            @(negedge clk);
            #1;
        end
        a_gap = 1'b0;
        b_gap = 1'b0;
        total++;
        if (ea != 40 || eb != 40)
            $display("FAIL alt_count got %0d/%0d want 40/40", ea, eb);
        else passed++;
        total++;
        if (aover != 0 || bover != 0)
            $display("FAIL alt_occ_bound got %0d/%0d want 0/0", aover, bover);
        else passed++;
        total++;
        if (a_ovf !== 1'b0 || b_ovf !== 1'b0)
            $display("FAIL alt_ovf got %b/%b want 0/0", a_ovf, b_ovf);
        else passed++;
        total++;
        if (a_err != 0 || b_err != 0)
            $display("FAIL alt_empty_err got %0d/%0d want 0/0", a_err, b_err);
        else passed++;
    endtask

    task automatic test_flush();
        int exp = 32'h25;
        a_ready = 1'b0;
        for (int i = 0; i < 8; i++) amem[awr + i] = 32'h21 + 32'(i);
        awr = awr + 8;
        repeat (4) @(negedge clk);
        #1;
        total++;
        if (a_occ !== 3'd3 || a_rd_op !== 1'b0)
            $display("FAIL flush_pre got occ %0d rd %b want 3/0", a_occ, a_rd_op);
        else passed++;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        total++;
        if (a_valid !== 1'b0 || a_occ !== 3'd0)
            $display("FAIL flush_post got %b/%0d want 0/0", a_valid, a_occ);
        else passed++;
        a_ready = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (a_occ !== 3'd0) $display("FAIL flush_late got %0d want 0", a_occ);
        else passed++;
        for (int c = 0; c < 20; c++) begin
            if (a_valid) begin
                total++;
                if (a_data !== 32'(exp))
                    $display("FAIL flush_data got %h want %h", a_data, exp);
                else passed++;
                exp++;
            end
            @(negedge clk);
            #1;
        end
        total++;
        if (exp != 32'h29) $display("FAIL flush_count got %h want 29", exp);
        else passed++;
    endtask

    task automatic test_async_reset();
        int exp = 32'h34;
        a_ready = 1'b1;
        for (int i = 0; i < 6; i++) amem[awr + i] = 32'h31 + 32'(i);
        awr = awr + 6;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (a_valid !== 1'b1 || a_data !== 32'h32)
            $display("FAIL ares_mid got %b/%h want 1/32", a_valid, a_data);
        else passed++;
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (a_rd_op !== 1'b0 || a_valid !== 1'b0 || a_occ !== 3'd0 || a_data !== 32'h0)
            $display("FAIL ares_now got %b/%b/%0d/%h want 0/0/0/0",
                     a_rd_op, a_valid, a_occ, a_data);
        else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        for (int c = 0; c < 20; c++) begin
            if (a_valid) begin
                total++;
                if (a_data !== 32'(exp))
                    $display("FAIL ares_data got %h want %h", a_data, exp);
                else passed++;
                exp++;
            end
            @(negedge clk);
            #1;
        end
        total++;
        if (exp != 32'h37) $display("FAIL ares_count got %h want 37", exp);
        else passed++;
    endtask

    initial begin
        reset_n = 1'b0;
        flush   = 1'b0;
        a_ready = 1'b0;
        b_ready = 1'b0;
        a_gap   = 1'b0;
        b_gap   = 1'b0;
        test_reset();
        test_throughput();
        test_backpressure();
        test_alternate();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
